risc_v_mike_mmio_gpio: RTL
==========================

// Module: risc_v_mike_mmio_gpio
// PURPOSE
//  MMIO responder at the far end of the data-memory bus. Takes the mmio write strobe/address from risc_v_mem_ctrl
//  (data_mmio_wr_addr_val/_addr) plus a read strobe/address, and exposes 2 output / 2 input GPIO words.
//  Provides rising-edge capture and a maskable IRQ. Read data returns 1 cycle later for the result-src mux.
// PARAMETERS
//  MMIO_BASE    32'hFFFF0000  byte base of register window; offsets below are relative to it
//  SYNC_STAGES  2             flops in each gpio_in synchronizer chain (legal values: 2..3)
// PORTS
//  clk             in   1   core clock; single clock domain
//  rst             in   1   synchronous, active-high reset
//  mmio_wr_val     in   1   write strobe (from data_mmio_wr_addr_val)
//  mmio_wr_addr    in   32  byte write address
//  mmio_wr_data    in   32  write data (reg_file_rd_data_2)
//  mmio_rd_val     in   1   read strobe
//  mmio_rd_addr    in   32  byte read address
//  mmio_rd_data    out  32  read data, valid when mmio_rd_data_val
//  mmio_rd_data_val out 1   read response; high exactly 1 cycle after an accepted mmio_rd_val
//  mmio_addr_error out  1   1-cycle pulse: unmapped offset or addr[1:0]!=0 on rd or wr
//  gpio_in0        in   32  asynchronous input word 0
//  gpio_in1        in   32  asynchronous input word 1
//  gpio_out0       out  32  registered output word 0
//  gpio_out1       out  32  registered output word 1
//  gpio_irq        out  1   |(EDGE_STAT & EDGE_MASK), registered
// BEHAVIOUR
//  Register map (offset: name, access):
//   0x00 OUT0 RW | 0x04 OUT1 RW | 0x08 IN0 RO (synchronized) | 0x0C IN1 RO (synchronized)
//   0x10 EDGE_STAT W1C (rising edges of synchronized in0) | 0x14 EDGE_MASK RW
//   0x18 OUT0_SET WO (OUT0 |= data) | 0x1C OUT0_CLR WO (OUT0 &= ~data); reads of 0x18/0x1C return 0
//  Decode: hit = addr[31:5]==MMIO_BASE[31:5] && addr[1:0]==0; other addresses -> mmio_addr_error, no state change.
//  Writes take effect on the clk edge where mmio_wr_val=1; gpio_out* change the cycle after.
//  Writes to RO offsets (0x08/0x0C) are ignored without error.
//  Reads: registered; rd_data = value before any same-cycle write (read-old on rd/wr collision).
//  mmio_rd_data holds its last value when rd_data_val=0. Error reads return 32'h0 with rd_data_val=1.
//  Sync: each input bit passes SYNC_STAGES flops; edge = sync & ~sync_d (one extra flop).
//   IN0 -> first visible on read SYNC_STAGES cycles after change; EDGE_STAT bit set SYNC_STAGES+1 cycles after.
//  EDGE_STAT next = (STAT & ~w1c_mask) | edge; a new edge in the same cycle as W1C of that bit wins (bit stays 1).
//  gpio_irq is registered from next-state STAT/MASK (asserts the cycle STAT/MASK update becomes visible).
//  Reset (sync, rst=1 at clk edge): OUT0=OUT1=0, EDGE_STAT=0, EDGE_MASK=0, sync chains=0, rd_data=0,
//   rd_data_val=0, addr_error=0, gpio_irq=0. Strobes during rst are dropped. A read in flight at rst yields no response.
//  Post-reset, chains start from 0, so inputs already high at reset create one edge SYNC_STAGES+1 cycles later.
// STRUCTURE
//  risc_v_mike_pkg: t_mmio_gpio_reg enum (offsets 0x00..0x1C), MMIO_GPIO_BASE, MMIO_GPIO_NUM_REGS.
//  Sub-module: risc_v_mike_sync_edge (SYNC_STAGES, WIDTH) = synchronizer + rising-edge pulse. Instantiated for
//  in0 (edge used) and in1 (edge unused). Decode, register file, and read mux stay in the top.
// TESTING
//  1 rst=1 for 2 cycles, gpio_in0=all-ones -> all outputs 0; EDGE_STAT=32'hFFFFFFFF at cycle SYNC_STAGES+1 after release.
//  2 wr 0xFFFF0000<-32'hA5A5_0F0F, then wr 0x18<-32'h0000_00F0, wr 0x1C<-32'h0000_000F
//    -> gpio_out0 = A5A50F0F, then A5A50FFF, then A5A50FF0; each change 1 cycle after its write.
//  3 Same-cycle rd and wr on 0x04: wr 0x1234_5678 over old 0
//    -> rd_data=0 with rd_data_val=1 next cycle; next read returns 0x12345678.
//  4 gpio_in0 bit3 0->1 with MASK=0x8 -> STAT=0x8 and gpio_irq=1 at SYNC_STAGES+1 cycles.
//    W1C 0x8 -> irq=0 next cycle. W1C aligned to a second edge cycle -> bit stays 1.
//  5 wr 0xFFFF0022 and rd 0xFFFF0100 -> mmio_addr_error pulse each, no register change, rd_data=0.
//  6 rst asserted the cycle after mmio_rd_val -> no rd_data_val; all registers zero the next cycle.

Source files
------------

// File: rtl/risc_v_mike_pkg.sv
// Shared definitions for the mike MMIO GPIO block: register offsets, window base, decode helper.
package risc_v_mike_pkg;

  localparam logic [31:0] MMIO_GPIO_BASE     = 32'hFFFF_0000;
  localparam int unsigned MMIO_GPIO_NUM_REGS = 8;

  typedef enum logic [4:0] {
    RegOut0     = 5'h00,
    RegOut1     = 5'h04,
    RegIn0      = 5'h08,
    RegIn1      = 5'h0C,
    RegEdgeStat = 5'h10,
    RegEdgeMask = 5'h14,
    RegOut0Set  = 5'h18,
    RegOut0Clr  = 5'h1C
  } t_mmio_gpio_reg;

  // Every word-aligned offset inside the 32-byte window is mapped.
  function automatic logic mmio_addr_hit(input logic [31:0] addr, input logic [26:0] base_hi);
    return (addr[31:5] == base_hi) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/risc_v_mike_sync_edge.sv
// Multi-flop input synchronizer with a one-cycle rising-edge pulse per bit.
module risc_v_mike_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WIDTH       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_stages
    $error("SYNC_STAGES must be 2 or 3");
  end

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      sync_prev_q <= '0;
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      sync_prev_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~sync_prev_q;

endmodule

// File: rtl/risc_v_mike_mmio_gpio.sv
// MMIO GPIO responder: two output words, two synchronized input words, rising-edge capture and IRQ.
module risc_v_mike_mmio_gpio
  import risc_v_mike_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE   = MMIO_GPIO_BASE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_wr_val,
  input  logic [31:0] mmio_wr_addr,
  input  logic [31:0] mmio_wr_data,
  input  logic        mmio_rd_val,
  input  logic [31:0] mmio_rd_addr,
  output logic [31:0] mmio_rd_data,
  output logic        mmio_rd_data_val,
  output logic        mmio_addr_error,
  input  logic [31:0] gpio_in0,
  input  logic [31:0] gpio_in1,
  output logic [31:0] gpio_out0,
  output logic [31:0] gpio_out1,
  output logic        gpio_irq
);

  logic [31:0] out0_q, out0_d, out1_q, out1_d;
  logic [31:0] stat_q, stat_d, mask_q, mask_d;
  logic [31:0] rd_data_q, rd_word;
  logic        rd_data_val_q, addr_error_q, irq_q;
  logic [31:0] in0_sync, in0_rise, in1_sync, in1_rise_unused;
  logic        wr_hit, rd_hit, wr_en;
  logic [31:0] w1c;

  t_mmio_gpio_reg wr_reg, rd_reg;

  risc_v_mike_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(32)) u_sync_in0 (
    .clk_i  (clk),
    .rst_i  (rst),
    .data_i (gpio_in0),
    .sync_o (in0_sync),
    .rise_o (in0_rise)
  );

  risc_v_mike_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(32)) u_sync_in1 (
    .clk_i  (clk),
    .rst_i  (rst),
    .data_i (gpio_in1),
    .sync_o (in1_sync),
    .rise_o (in1_rise_unused)
  );

  assign wr_hit = mmio_addr_hit(mmio_wr_addr, MMIO_BASE[31:5]);
  assign rd_hit = mmio_addr_hit(mmio_rd_addr, MMIO_BASE[31:5]);
  assign wr_en  = mmio_wr_val && wr_hit;
  assign wr_reg = t_mmio_gpio_reg'(mmio_wr_addr[4:0]);
  assign rd_reg = t_mmio_gpio_reg'(mmio_rd_addr[4:0]);

  always_comb begin
    out0_d = out0_q;
    out1_d = out1_q;
    mask_d = mask_q;
    w1c    = '0;
    if (wr_en) begin
      case (wr_reg)
        RegOut0:     out0_d = mmio_wr_data;
        RegOut1:     out1_d = mmio_wr_data;
        RegEdgeStat: w1c    = mmio_wr_data;
        RegEdgeMask: mask_d = mmio_wr_data;
        RegOut0Set:  out0_d = out0_q | mmio_wr_data;
        RegOut0Clr:  out0_d = out0_q & ~mmio_wr_data;
        default:     ;
      endcase
    end
    // A fresh edge overrides a same-cycle clear of that bit.
    stat_d = (stat_q & ~w1c) | in0_rise;
  end

  // Read mux sees pre-write state, giving read-old on a rd/wr collision.
  always_comb begin
    rd_word = '0;
    if (rd_hit) begin
      case (rd_reg)
        RegOut0:     rd_word = out0_q;
        RegOut1:     rd_word = out1_q;
        RegIn0:      rd_word = in0_sync;
        RegIn1:      rd_word = in1_sync;
        RegEdgeStat: rd_word = stat_q;
        RegEdgeMask: rd_word = mask_q;
        default:     rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out0_q        <= '0;
      out1_q        <= '0;
      stat_q        <= '0;
      mask_q        <= '0;
      rd_data_q     <= '0;
      rd_data_val_q <= 1'b0;
      addr_error_q  <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      out0_q        <= out0_d;
      out1_q        <= out1_d;
      stat_q        <= stat_d;
      mask_q        <= mask_d;
      rd_data_val_q <= mmio_rd_val;
      if (mmio_rd_val) rd_data_q <= rd_word;
      addr_error_q  <= (mmio_wr_val && !wr_hit) || (mmio_rd_val && !rd_hit);
      irq_q         <= |(stat_d & mask_d);
    end
  end

  // Suppress a response whose cycle coincides with reset.
  assign mmio_rd_data_val = rd_data_val_q & ~rst;
  assign mmio_rd_data     = rd_data_q;
  assign mmio_addr_error  = addr_error_q;
  assign gpio_out0        = out0_q;
  assign gpio_out1        = out1_q;
  assign gpio_irq         = irq_q;

endmodule
